// File: rtl/multiword_adder_seq.sv
// Sequential W-bit adder built around an external 16-bit adder: one slice per cycle,
// carry chained through carry_reg, valid/ready handshake on both sides.
module multiword_adder_seq #(
   parameter int WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [16*WORDS-1:0]   a,
   input  logic [16*WORDS-1:0]   b,
   input  logic                  c_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [16*WORDS-1:0]   sum,
   output logic                  c_out,
   output logic                  ovf,
   output logic [15:0]           add_a,
   output logic [15:0]           add_b,
   output logic                  add_cin,
   input  logic [15:0]           add_sum,
   input  logic                  add_cout
);

   localparam int W  = 16 * WORDS;
   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [W-1:0]    a_reg, b_reg, sum_reg, sum_shift;
   logic            carry_reg, a_msb, b_msb;
   logic [CW-1:0]   cnt;
   logic            last_slice, accept;

   assign last_slice = (cnt == CW'(WORDS - 1));
   assign accept     = in_valid && in_ready;

   // New slice enters at the top so slice 0 ends up in the low 16 bits after WORDS shifts.
   generate
      if (WORDS == 1) begin : g_single
         assign sum_shift = add_sum;
      end else begin : g_multi
         assign sum_shift = {add_sum, sum_reg[W-1:16]};
      end
   endgenerate

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      add_a      = '0;
      add_b      = '0;
      add_cin    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_next = RUN;
         end
         RUN: begin
            add_a   = a_reg[15:0];
            add_b   = b_reg[15:0];
            add_cin = carry_reg;
            if (last_slice) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         a_msb     <= 1'b0;
         b_msb     <= 1'b0;
         cnt       <= '0;
      end else if (accept) begin
         a_reg     <= a;
         b_reg     <= b;
         carry_reg <= c_in;
         a_msb     <= a[W-1];
         b_msb     <= b[W-1];
         cnt       <= '0;
      end else if (state == RUN) begin
         sum_reg   <= sum_shift;
         a_reg     <= a_reg >> 16;
         b_reg     <= b_reg >> 16;
         carry_reg <= add_cout;
         cnt       <= cnt + CW'(1);
      end
   end

   assign sum   = sum_reg;
   assign c_out = carry_reg;
   assign ovf   = (a_msb == b_msb) && (sum_reg[W-1] != a_msb);

endmodule
